// File: rtl/param_reg_file_pkg.sv
// rtl/param_reg_file_pkg.sv - shared FunSel encodings and types for the parameterised register file
//
// Purpose : operation codes driven on FunSel, shared by the top level and every register cell.

package param_reg_file_pkg;

    typedef logic [1:0] fun_sel_t;

    localparam fun_sel_t FS_DEC   = 2'b00;
    localparam fun_sel_t FS_INC   = 2'b01;
    localparam fun_sel_t FS_LOAD  = 2'b10;
    localparam fun_sel_t FS_CLEAR = 2'b11;

endpackage

// File: rtl/param_reg_file_reg_cell.sv
// rtl/param_reg_file_reg_cell.sv - one WIDTH-bit register with op decode, saturation and Ovf/Zero flags
//
// Purpose : a single register of the file. When en_i is high it executes fun_sel_i on the
//           rising edge; otherwise it holds. Tracks a sticky overflow/underflow flag.
// Ports   : Clock, Reset (synchronous, active-low)
//           fun_sel_i   - operation (DEC/INC/LOAD/CLEAR)
//           en_i        - write enable for this register
//           load_data_i - value stored by LOAD
//           value_o     - stored value
//           ovf_o       - sticky overflow/underflow flag
//           zero_o      - high when the stored value is 0

module reg_cell
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  fun_sel_t         fun_sel_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic [WIDTH-1:0] value_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        value_d = value_q;
        ovf_d   = ovf_q;
        if (en_i) begin
            case (fun_sel_i)
                FS_DEC: begin
                    if (value_q == ALL_ZERO) begin
                        // Underflow flags in both modes; only the stored value differs.
                        ovf_d   = 1'b1;
                        value_d = (SAT != 0) ? ALL_ZERO : ALL_ONES;
                    end else begin
                        value_d = value_q - ONE;
                    end
                end
                FS_INC: begin
                    if (value_q == ALL_ONES) begin
                        ovf_d   = 1'b1;
                        value_d = (SAT != 0) ? ALL_ONES : ALL_ZERO;
                    end else begin
                        value_d = value_q + ONE;
                    end
                end
                FS_LOAD: begin
                    // LOAD leaves the sticky flag alone on purpose.
                    value_d = load_data_i;
                end
                default: begin
                    value_d = ALL_ZERO;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            value_q <= ALL_ZERO;
            ovf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign value_o = value_q;
    assign ovf_o   = ovf_q;
    assign zero_o  = (value_q == ALL_ZERO);

endmodule

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - DEPTH x WIDTH register file with per-register INC/DEC/LOAD/CLEAR and two read ports
//
// Purpose : DEPTH independent registers, each updated when its RegSel bit is set, plus two
//           combinational read ports. Selects at or beyond DEPTH read as 0.
// Ports   : Clock, Reset (synchronous, active-low)
//           FunSel  - operation applied to every selected register
//           RegSel  - per-register write enable
//           I       - load data
//           OutASel, OutBSel / OutA, OutB - read selects and read data
//           Ovf     - per-register sticky overflow/underflow flags
//           Zero    - per-register "value is 0" flags

module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SAT   = 0
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [1:0]               FunSel,
    input  logic [DEPTH-1:0]         RegSel,
    input  logic [WIDTH-1:0]         I,
    input  logic [$clog2(DEPTH)-1:0] OutASel,
    input  logic [$clog2(DEPTH)-1:0] OutBSel,
    output logic [WIDTH-1:0]         OutA,
    output logic [WIDTH-1:0]         OutB,
    output logic [DEPTH-1:0]         Ovf,
    output logic [DEPTH-1:0]         Zero
);

    localparam int SELW = $clog2(DEPTH);

    logic [WIDTH-1:0] reg_val [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_cell #(
            .WIDTH (WIDTH),
            .SAT   (SAT)
        ) u_cell (
            .Clock       (Clock),
            .Reset       (Reset),
            .fun_sel_i   (fun_sel_t'(FunSel)),
            .en_i        (RegSel[g]),
            .load_data_i (I),
            .value_o     (reg_val[g]),
            .ovf_o       (Ovf[g]),
            .zero_o      (Zero[g])
        );
    end

    // Compare-and-select rather than direct indexing, so selects past DEPTH fall through to 0.
    always_comb begin
        OutA = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (OutASel == SELW'(i)) begin
                OutA = reg_val[i];
            end
        end
    end

    always_comb begin
        OutB = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (OutBSel == SELW'(i)) begin
                OutB = reg_val[i];
            end
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - self-checking bench for param_reg_file (wrap and saturate instances)

module tb_param_reg_file;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [1:0] FunSel;
    logic [7:0] I;

    logic [3:0] rs0;
    logic [1:0] a0, b0;
    logic [7:0] oa0, ob0;
    logic [3:0] ovf0, z0;

    logic [4:0] rs1;
    logic [2:0] a1, b1;
    logic [7:0] oa1, ob1;
    logic [4:0] ovf1, z1;

    int  m0 [4];
    bit  f0 [4];
    int  m1 [5];
    bit  f1 [5];
    int  checks = 0;
    int  errors = 0;

    always #5 Clock = ~Clock;

    param_reg_file #(.WIDTH(8), .DEPTH(4), .SAT(0)) dut_wrap (
        .Clock(Clock), .Reset(Reset), .FunSel(FunSel), .RegSel(rs0), .I(I),
        .OutASel(a0), .OutBSel(b0), .OutA(oa0), .OutB(ob0), .Ovf(ovf0), .Zero(z0)
    );

    param_reg_file #(.WIDTH(8), .DEPTH(5), .SAT(1)) dut_sat (
        .Clock(Clock), .Reset(Reset), .FunSel(FunSel), .RegSel(rs1), .I(I),
        .OutASel(a1), .OutBSel(b1), .OutA(oa1), .OutB(ob1), .Ovf(ovf1), .Zero(z1)
    );

    function automatic int next_val(input int v, input int fs, input int sat, input int din);
        case (fs)
            0: return (v == 0)   ? ((sat != 0) ? 0 : 255)   : v - 1;
            1: return (v == 255) ? ((sat != 0) ? 255 : 0)   : v + 1;
            2: return din;
            default: return 0;
        endcase
    endfunction

    function automatic bit next_flag(input int v, input int fs, input bit f);
        if (fs == 3) return 1'b0;
        if (fs == 1 && v == 255) return 1'b1;
        if (fs == 0 && v == 0) return 1'b1;
        return f;
    endfunction

    // Drive one operation, advance one edge, and advance the reference model.
    task automatic cycle(input logic [1:0] fs, input logic [3:0] s0, input logic [4:0] s1,
                         input logic [7:0] d, input logic rst);
        FunSel = fs; rs0 = s0; rs1 = s1; I = d; Reset = rst;
        @(posedge Clock);
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin m0[i] = 0; f0[i] = 0; end
            for (int i = 0; i < 5; i++) begin m1[i] = 0; f1[i] = 0; end
        end else begin
            for (int i = 0; i < 4; i++) if (s0[i]) begin
                f0[i] = next_flag(m0[i], fs, f0[i]);
                m0[i] = next_val(m0[i], fs, 0, d);
            end
            for (int i = 0; i < 5; i++) if (s1[i]) begin
                f1[i] = next_flag(m1[i], fs, f1[i]);
                m1[i] = next_val(m1[i], fs, 1, d);
            end
        end
        #1;
        Reset = 1'b1; rs0 = '0; rs1 = '0;
    endtask

    task automatic test_reset;
        cycle(2'($urandom_range(0, 3)), 4'hF, 5'h1F, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) begin
            a0 = 2'(i); b0 = 2'(i); #1;
            checks++;
            if (oa0 !== 8'h00 || ob0 !== 8'h00) begin
                errors++; $display("FAIL reset_read%0d: got A=%h B=%h expected 00", i, oa0, ob0);
            end
        end
        checks++;
        if (ovf0 !== 4'b0000 || z0 !== 4'b1111) begin
            errors++; $display("FAIL reset_flags: got Ovf=%b Zero=%b expected 0000/1111", ovf0, z0);
        end
        checks++;
        if (ovf1 !== 5'b00000 || z1 !== 5'b11111) begin
            errors++; $display("FAIL reset_flags_sat: got Ovf=%b Zero=%b expected 00000/11111", ovf1, z1);
        end
    endtask

    task automatic test_load_pattern;
        cycle(2'b10, 4'b0101, 5'b00000, 8'hAA, 1'b1);
        a0 = 2'd0; b0 = 2'd2; #1;
        checks++;
        if (oa0 !== 8'hAA || ob0 !== 8'hAA) begin
            errors++; $display("FAIL load_read: got A=%h B=%h expected AA AA", oa0, ob0);
        end
        a0 = 2'd1; b0 = 2'd3; #1;
        checks++;
        if (oa0 !== 8'h00 || ob0 !== 8'h00) begin
            errors++; $display("FAIL load_unselected: got A=%h B=%h expected 00 00", oa0, ob0);
        end
        checks++;
        if (z0 !== 4'b1010) begin
            errors++; $display("FAIL load_zero: got %b expected 1010", z0);
        end
    endtask

    task automatic test_wrap;
        cycle(2'b10, 4'b0010, 5'b0, 8'hFF, 1'b1);
        cycle(2'b01, 4'b0010, 5'b0, 8'h00, 1'b1);
        a0 = 2'd1; #1;
        checks++;
        if (oa0 !== 8'h00 || ovf0[1] !== 1'b1) begin
            errors++; $display("FAIL wrap_inc: got val=%h ovf=%b expected 00/1", oa0, ovf0[1]);
        end
        cycle(2'b10, 4'b0010, 5'b0, 8'h05, 1'b1);
        #1;
        checks++;
        if (oa0 !== 8'h05 || ovf0[1] !== 1'b1) begin
            errors++; $display("FAIL wrap_load_sticky: got val=%h ovf=%b expected 05/1", oa0, ovf0[1]);
        end
        cycle(2'b11, 4'b0010, 5'b0, 8'h00, 1'b1);
        #1;
        checks++;
        if (oa0 !== 8'h00 || ovf0[1] !== 1'b0) begin
            errors++; $display("FAIL wrap_clear: got val=%h ovf=%b expected 00/0", oa0, ovf0[1]);
        end
    endtask

    task automatic test_saturate;
        cycle(2'b11, 4'b0, 5'b01000, 8'h00, 1'b1);
        cycle(2'b00, 4'b0, 5'b01000, 8'h00, 1'b1);
        a1 = 3'd3; #1;
        checks++;
        if (oa1 !== 8'h00 || ovf1[3] !== 1'b1) begin
            errors++; $display("FAIL sat_dec: got val=%h ovf=%b expected 00/1", oa1, ovf1[3]);
        end
        cycle(2'b10, 4'b0, 5'b01000, 8'hFE, 1'b1);
        cycle(2'b01, 4'b0, 5'b01000, 8'h00, 1'b1);
        #1;
        checks++;
        if (oa1 !== 8'hFF || ovf1[3] !== 1'b1) begin
            errors++; $display("FAIL sat_inc1: got val=%h ovf=%b expected FF/1", oa1, ovf1[3]);
        end
        cycle(2'b01, 4'b0, 5'b01000, 8'h00, 1'b1);
        #1;
        checks++;
        if (oa1 !== 8'hFF || ovf1[3] !== 1'b1) begin
            errors++; $display("FAIL sat_inc2: got val=%h ovf=%b expected FF/1", oa1, ovf1[3]);
        end
    endtask

    task automatic test_reset_override;
        cycle(2'b10, 4'hF, 5'h1F, 8'h77, 1'b1);
        cycle(2'b10, 4'hF, 5'h1F, 8'h33, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a0 = 2'(i); a1 = 3'(i); #1;
            checks++;
            if (oa0 !== 8'h00 || oa1 !== 8'h00) begin
                errors++; $display("FAIL reset_override%0d: got %h/%h expected 00", i, oa0, oa1);
            end
        end
        cycle(2'b10, 4'b0001, 5'b0, 8'h42, 1'b1);
        a0 = 2'd0; #1;
        checks++;
        if (oa0 !== 8'h42) begin
            errors++; $display("FAIL post_reset_op: got %h expected 42", oa0);
        end
    endtask

    task automatic test_same_edge_read;
        cycle(2'b10, 4'b1000, 5'b0, 8'h10, 1'b1);
        a0 = 2'd3; b0 = 2'd3;
        FunSel = 2'b01; rs0 = 4'b1000; rs1 = 5'b0; I = 8'h00; Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if (oa0 !== 8'h10 || ob0 !== 8'h10) begin
            errors++; $display("FAIL read_before_edge: got A=%h B=%h expected 10 10", oa0, ob0);
        end
        cycle(2'b01, 4'b1000, 5'b0, 8'h00, 1'b1);
        checks++;
        if (oa0 !== 8'h11 || ob0 !== 8'h11) begin
            errors++; $display("FAIL read_after_edge: got A=%h B=%h expected 11 11", oa0, ob0);
        end
    endtask

    task automatic test_out_of_range;
        cycle(2'b10, 4'h0, 5'h1F, 8'hFF, 1'b1);
        for (int s = 5; s < 8; s++) begin
            a1 = 3'(s); b1 = 3'(s); #1;
            checks++;
            if (oa1 !== 8'h00 || ob1 !== 8'h00) begin
                errors++; $display("FAIL oob_sel%0d: got A=%h B=%h expected 00", s, oa1, ob1);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic [3:0] eo0, ez0;
        logic [4:0] eo1, ez1;
        int ea, eb;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: d = 8'h00;
                1: d = 8'hFF;
                2: d = 8'($urandom_range(0, 1) ? 8'h01 : 8'hFE);
                default: d = 8'($urandom);
            endcase
            cycle(2'($urandom_range(0, 3)), 4'($urandom), 5'($urandom), d,
                  logic'($urandom_range(0, 39) != 0));
            a0 = 2'($urandom); b0 = 2'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
            #1;
            for (int i = 0; i < 4; i++) begin eo0[i] = f0[i]; ez0[i] = (m0[i] == 0); end
            for (int i = 0; i < 5; i++) begin eo1[i] = f1[i]; ez1[i] = (m1[i] == 0); end
            checks++;
            if (oa0 !== 8'(m0[a0]) || ob0 !== 8'(m0[b0])) begin
                errors++; $display("FAIL rand_wrap_read n=%0d: got A=%h B=%h expected %h %h",
                                   n, oa0, ob0, 8'(m0[a0]), 8'(m0[b0]));
            end
            checks++;
            if (ovf0 !== eo0 || z0 !== ez0) begin
                errors++; $display("FAIL rand_wrap_flags n=%0d: got Ovf=%b Zero=%b expected %b %b",
                                   n, ovf0, z0, eo0, ez0);
            end
            ea = (a1 < 5) ? m1[a1] : 0;
            eb = (b1 < 5) ? m1[b1] : 0;
            checks++;
            if (oa1 !== 8'(ea) || ob1 !== 8'(eb)) begin
                errors++; $display("FAIL rand_sat_read n=%0d: got A=%h B=%h expected %h %h",
                                   n, oa1, ob1, 8'(ea), 8'(eb));
            end
            checks++;
            if (ovf1 !== eo1 || z1 !== ez1) begin
                errors++; $display("FAIL rand_sat_flags n=%0d: got Ovf=%b Zero=%b expected %b %b",
                                   n, ovf1, z1, eo1, ez1);
            end
        end
    endtask

    initial begin
        Reset = 1'b0; FunSel = 2'b00; I = 8'h00;
        rs0 = '0; rs1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int i = 0; i < 4; i++) begin m0[i] = 0; f0[i] = 0; end
        for (int i = 0; i < 5; i++) begin m1[i] = 0; f1[i] = 0; end
        @(negedge Clock);
        test_reset;
        test_load_pattern;
        test_wrap;
        test_saturate;
        test_reset_override;
        test_same_edge_read;
        test_out_of_range;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
